// File: rtl/layer_bias_sequencer.sv
// Bias-add stage between the adder-tree accumulators and the activation buffer.
// Walks groups (outer) by pixels (inner); saturating signed add with optional ReLU.
module layer_bias_sequencer #(
  parameter int N_adder_tree = 16,
  parameter int W            = 18,
  parameter int N_GROUPS     = 4,
  parameter int N_PIXELS     = 196,
  parameter int RELU         = 1,
  localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
  localparam int PW = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1,
  localparam int VW = N_adder_tree * W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N_GROUPS*VW-1:0] bias_bus,
  input  logic [VW-1:0]          acc_data,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  output logic [VW-1:0]          out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [GW-1:0]          grp_idx,
  output logic [PW-1:0]          pix_idx,
  output logic                   busy,
  output logic                   done
);

  // state | meaning
  // IDLE  | waiting for start; accumulator beats ignored
  // RUN   | accepting beats, one output register in flight
  // DRAIN | all beats accepted; waiting for the out_last handshake
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   grp_nx;
  logic [PW-1:0]   pix_nx;
  logic            out_valid_nx, out_last_nx;
  logic [VW-1:0]   out_data_nx;
  logic [VW-1:0]   bias_sel;
  logic [VW-1:0]   biased;
  logic            accept, out_hs, last_pix, last_beat;

  assign acc_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept    = acc_valid && acc_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_pix  = (pix_idx == PW'(N_PIXELS - 1));
  assign last_beat = last_pix && (grp_idx == GW'(N_GROUPS - 1));
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

  always_comb begin
    bias_sel = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      if (grp_idx == GW'(g)) bias_sel = bias_bus[g*VW +: VW];
    end
  end

  // Overflow shows up as disagreement between the two top bits of the W+1 sum.
  for (genvar l = 0; l < N_adder_tree; l++) begin : g_lane
    logic [W-1:0] a, b, sat;
    logic [W:0]   sum;
    assign a   = acc_data[W*l +: W];
    assign b   = bias_sel[W*l +: W];
    assign sum = {a[W-1], a} + {b[W-1], b};
    assign sat = (sum[W] == sum[W-1]) ? sum[W-1:0] :
                 (sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});
    assign biased[W*l +: W] = ((RELU != 0) && sat[W-1]) ? '0 : sat;
  end

  always_comb begin
    state_nx     = state;
    grp_nx       = grp_idx;
    pix_nx       = pix_idx;
    out_valid_nx = out_valid;
    out_last_nx  = out_last;
    out_data_nx  = out_data;
    if (out_hs) begin
      out_valid_nx = 1'b0;
      out_last_nx  = 1'b0;
    end
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          grp_nx   = '0;
          pix_nx   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          out_valid_nx = 1'b1;
          out_data_nx  = biased;
          out_last_nx  = last_beat;
          if (last_beat) begin
            grp_nx   = '0;
            pix_nx   = '0;
            state_nx = DRAIN;
          end else if (last_pix) begin
            pix_nx = '0;
            grp_nx = grp_idx + GW'(1);
          end else begin
            pix_nx = pix_idx + PW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_hs && out_last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grp_idx   <= '0;
      pix_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nx;
      grp_idx   <= grp_nx;
      pix_idx   <= pix_nx;
      out_valid <= out_valid_nx;
      out_last  <= out_last_nx;
      out_data  <= out_data_nx;
    end
  end

endmodule

// File: tb/tb_layer_bias_sequencer.sv
// Randomized bench for layer_bias_sequencer; two instances (RELU off/on) share stimulus
// and are compared against a beat-level reference model.
module tb_layer_bias_sequencer;
  localparam int NL = 16;
  localparam int W  = 18;
  localparam int NG = 4;
  localparam int NP = 2;
  localparam int VW = NL * W;
  localparam int NB = NG * NP;

  logic             clk;
  logic             rst_n, start, acc_valid, out_ready;
  logic [NG*VW-1:0] bias_bus;
  logic [VW-1:0]    acc_data;
  logic             acc_ready_a, out_valid_a, out_last_a, busy_a, done_a;
  logic             acc_ready_b, out_valid_b, out_last_b, busy_b, done_b;
  logic [VW-1:0]    out_data_a, out_data_b;
  logic [1:0]       grp_a, grp_b;
  logic             pix_a, pix_b;

  layer_bias_sequencer #(.N_adder_tree(NL), .W(W), .N_GROUPS(NG), .N_PIXELS(NP), .RELU(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bias_bus(bias_bus), .acc_data(acc_data),
    .acc_valid(acc_valid), .acc_ready(acc_ready_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_last(out_last_a), .grp_idx(grp_a), .pix_idx(pix_a),
    .busy(busy_a), .done(done_a));

  layer_bias_sequencer #(.N_adder_tree(NL), .W(W), .N_GROUPS(NG), .N_PIXELS(NP), .RELU(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bias_bus(bias_bus), .acc_data(acc_data),
    .acc_valid(acc_valid), .acc_ready(acc_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_last(out_last_b), .grp_idx(grp_b), .pix_idx(pix_b),
    .busy(busy_b), .done(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] d0;
    logic [VW-1:0] d1;
    int            idx;
  } beat_t;

  // model: phase 0 idle, 1 run, 2 drain, 3 done
  int            ph;
  int            n_acc;
  beat_t         q[$];
  beat_t         popped;
  logic [VW-1:0] hold0, hold1;
  int            vectors, miscompares;
  int            obs_out, done_cnt;
  bit            dir_layer;

  logic [W-1:0] dir_acc  [NB];
  logic [W-1:0] dir_exp0 [NB];
  logic [W-1:0] dir_exp1 [NB];
  logic [W-1:0] dir_bias [NG];

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] ref_vec(input logic [VW-1:0] acc, input logic [VW-1:0] b, input bit relu);
    logic [VW-1:0] r;
    logic [31:0]   su;
    int            s;
    r = '0;
    for (int l = 0; l < NL; l++) begin
      s = int'($signed(acc[W*l +: W])) + int'($signed(b[W*l +: W]));
      if (s > 131071) s = 131071;
      if (s < -131072) s = -131072;
      if (relu && s < 0) s = 0;
      su = 32'(s);
      r[W*l +: W] = su[W-1:0];
    end
    return r;
  endfunction

  task automatic check_all();
    bit pend;
    int eg, ep;
    pend = (q.size() > 0);
    eg = (ph == 1) ? n_acc / NP : 0;
    ep = (ph == 1) ? n_acc % NP : 0;
    chk("acc_ready", acc_ready_a, (ph == 1) && (!pend || out_ready));
    chk("acc_ready_relu", acc_ready_b, (ph == 1) && (!pend || out_ready));
    chk("out_valid", out_valid_a, pend);
    chk("out_valid_relu", out_valid_b, pend);
    chk("out_data", out_data_a, hold0);
    chk("out_data_relu", out_data_b, hold1);
    if (pend) begin
      chk("out_last", out_last_a, q[0].idx == NB - 1);
      chk("out_last_relu", out_last_b, q[0].idx == NB - 1);
    end
    chk("grp_idx", grp_a, eg[1:0]);
    chk("pix_idx", pix_a, ep[0]);
    chk("busy", busy_a, ph == 1 || ph == 2);
    chk("done", done_a, ph == 3);
    chk("done_relu", done_b, ph == 3);
  endtask

  task automatic step(input bit r, input bit st, input bit av, input bit orr);
    bit ready_e, acc_hs, out_hs;
    int sel;
    rst_n = r; start = st; acc_valid = av; out_ready = orr;
    for (int l = 0; l < NL; l++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: acc_data[W*l +: W] = W'($urandom);
        1: acc_data[W*l +: W] = 18'h1FFFF - W'($urandom_range(0, 4095));
        2: acc_data[W*l +: W] = 18'h20000 + W'($urandom_range(0, 4095));
        default: acc_data[W*l +: W] = W'($urandom_range(0, 511)) - 18'd256;
      endcase
    end
    if (dir_layer && ph == 1 && n_acc < NB) acc_data[W-1:0] = dir_acc[n_acc];
    if (out_valid_a && out_ready) obs_out++;
    if (done_a) done_cnt++;
    if (dir_layer && q.size() > 0 && orr) begin
      chk("dir_lane0", out_data_a[W-1:0], dir_exp0[q[0].idx]);
      chk("dir_lane0_relu", out_data_b[W-1:0], dir_exp1[q[0].idx]);
    end
    ready_e = (ph == 1) && (q.size() == 0 || orr);
    acc_hs  = ready_e && av;
    out_hs  = (q.size() > 0) && orr;
    if (!r) begin
      ph = 0; n_acc = 0; q.delete(); hold0 = '0; hold1 = '0;
    end else begin
      case (ph)
        0: if (st) begin ph = 1; n_acc = 0; end
        1: begin
          if (out_hs) popped = q.pop_front();
          if (acc_hs) begin
            popped.d0  = ref_vec(acc_data, bias_bus[(n_acc/NP)*VW +: VW], 1'b0);
            popped.d1  = ref_vec(acc_data, bias_bus[(n_acc/NP)*VW +: VW], 1'b1);
            popped.idx = n_acc;
            q.push_back(popped);
            hold0 = popped.d0; hold1 = popped.d1;
            n_acc++;
            if (n_acc == NB) ph = 2;
          end
        end
        2: if (out_hs) begin
          popped = q.pop_front();
          if (popped.idx == NB - 1) ph = 3;
        end
        default: ph = 0;
      endcase
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_bias();
    for (int i = 0; i < NG * NL; i++) bias_bus[W*i +: W] = W'($urandom);
  endtask

  // mode 0: out_ready high; 1: out_ready low for 3 cycles mid-layer; 2: random
  task automatic run_layer(input bit dir, input int mode, input bit av_rand);
    bit seen;
    bit orr, av;
    dir_layer = dir;
    obs_out = 0; done_cnt = 0; seen = 0;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("start_busy", busy_a, 1'b1);
    for (int c = 0; c < 300 && !seen; c++) begin
      orr = (mode == 0) ? 1'b1 : (mode == 1) ? !(c >= 3 && c < 6) : bit'($urandom_range(0, 1));
      av  = av_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      step(1'b1, bit'($urandom_range(0, 7) == 0), av, orr);
      if (done_a) seen = 1;
    end
    chk("layer_done", seen, 1'b1);
    chk("busy_at_done", busy_a, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("beats_out", obs_out, NB);
    chk("done_pulses", done_cnt, 1);
    dir_layer = 0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; ph = 0; n_acc = 0; hold0 = '0; hold1 = '0;
    dir_layer = 0; obs_out = 0; done_cnt = 0;
    rst_n = 0; start = 0; acc_valid = 0; out_ready = 0; acc_data = '0; bias_bus = '0;
    dir_bias = '{18'h00AE0, 18'h3FFF8, 18'h00010, 18'h3FFF8};
    dir_acc  = '{18'h00010, 18'h1FFFF, 18'h20000, 18'h00100, 18'h3FF00, 18'h00005, 18'h00100, 18'h3FFF0};
    dir_exp0 = '{18'h00AF0, 18'h1FFFF, 18'h20000, 18'h000F8, 18'h3FF10, 18'h00015, 18'h000F8, 18'h3FFE8};
    dir_exp1 = '{18'h00AF0, 18'h1FFFF, 18'h00000, 18'h000F8, 18'h00000, 18'h00015, 18'h000F8, 18'h00000};
    @(negedge clk);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst_out_last", out_last_a, 1'b0);
    chk("rst_out_data", out_data_a, '0);
    step(1'b1, 1'b0, 1'b1, 1'b1);

    rand_bias();
    for (int g = 0; g < NG; g++) bias_bus[g*VW +: W] = dir_bias[g];
    run_layer(1'b1, 0, 1'b0);

    rand_bias();
    run_layer(1'b0, 1, 1'b0);

    rand_bias();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("midrst_out_last", out_last_a, 1'b0);
    chk("midrst_busy", busy_a, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    run_layer(1'b0, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      rand_bias();
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) step(1'b1, 1'b0, 1'b1, 1'b1);
      run_layer(1'b0, 2, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/layer_bias_sequencer.md
# layer_bias_sequencer

Sequences the per-layer bias-add stage between the adder-tree accumulators and the next-layer activation buffer. It takes one lane vector of N_adder_tree accumulator results per beat, selects the bias vector for the current output-channel group from a flattened bank of constant BIAS instances, and performs a saturating signed add with optional ReLU. It walks a group-outer / pixel-inner schedule and signals layer completion. Weight and activation fetch logic uses its group and pixel indices.

## Interface
- N_adder_tree, 16, lanes per beat; one output channel per lane.
- W, 18, signed two's-complement data and bias width.
- N_GROUPS, 4, output-channel groups per layer; each group has its own bias vector.
- N_PIXELS, 196, pixels per group; must be ≥1.
- RELU, 1, 1 = clamp negative results to 0 after saturation; 0 = bypass.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin a layer; ignored unless state is IDLE.
- bias_bus  in  N_GROUPS*N_adder_tree*W  bias vectors; group g, lane l at bits [W*(g*N_adder_tree+l) +: W].
- acc_data  in  N_adder_tree*W  accumulator lanes; lane l at [W*l +: W].
- acc_valid  in  1  acc_data valid.
- acc_ready  out  1  beat accepted when acc_valid && acc_ready.
- out_data  out  N_adder_tree*W  biased, saturated results.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_last  out  1  qualifies the final beat of the layer.
- grp_idx  out  $clog2(N_GROUPS) (min 1)  group of the next beat to accept.
- pix_idx  out  $clog2(N_PIXELS) (min 1)  pixel of the next beat to accept.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at layer completion.

## Operation
- States:
  - IDLE: start → RUN; counters cleared.
  - RUN: after the last beat is accepted (grp_idx = N_GROUPS-1, pix_idx = N_PIXELS-1) → DRAIN.
  - DRAIN: when the last output handshake completes (out_valid && out_ready && out_last) → DONE.
  - DONE: → IDLE after one cycle; done = 1 only in DONE.
- acc_ready = (state == RUN) && (!out_valid || out_ready). Single output register, no bubbles under continuous flow.
- On accept, per lane: the sum is computed at W+1 bits. If it exceeds 2^(W-1)-1, the result clamps to 0x1FFFF (W=18). If it is below -2^(W-1), the result clamps to 0x20000. Then, if RELU = 1 and the result is negative, it becomes 0.
- The bias used is the vector for grp_idx at the accept cycle.
- Counter advance on accept:
  - pix_idx increments.
  - At N_PIXELS-1, pix_idx wraps to 0 and grp_idx increments.
  - At the final beat, both counters hold at 0 and out_last is registered as 1.
- In RUN, out_valid, out_data and out_last load together on accept. In RUN and DRAIN, out_valid clears when the output handshake completes and no new accept occurs in that cycle.
- In IDLE and DONE, acc_valid is ignored and no state changes.
- rst_n low at any point, including mid-layer, gives the reset values below at the next edge. A partially processed layer is discarded.

## Timing
- Reset values:
  - state = IDLE.
  - acc_ready = 0, out_valid = 0, out_last = 0, out_data = 0.
  - grp_idx = 0, pix_idx = 0.
  - busy = 0, done = 0.
- Latency: accept at edge k → out_valid = 1 after edge k; data visible in cycle k+1.
- Throughput: 1 beat/cycle while out_ready = 1.
- Back-pressure: out_ready = 0 with out_valid = 1 → acc_ready = 0. out_data and out_last stay stable until accepted.
- start → busy = 1 and acc_ready = 1 in the next cycle (output empty).
- Final accept → DRAIN. Handshake of the out_last beat → done pulses in the following cycle, and busy = 0 in that same cycle.
- start asserted together with done, or in DRAIN, is ignored.

## Test plan
- Basic add: N_GROUPS=4, N_PIXELS=2, RELU=0; group-0 lane-0 bias 0x00AE0, acc lane0 0x00010 → out lane0 0x00AF0 one cycle after accept.
- Saturation: acc lane0 0x1FFFF + bias 0x00AE0 → 0x1FFFF. Acc 0x20000 + bias 0x3FFF8 → 0x20000.
- ReLU: RELU=1, acc 0x3FF00 + bias 0x00010 → 0x00000. Acc 0x00100 + bias 0x3FFF8 → 0x000F8.
- Schedule, acc_valid held high, out_ready = 1:
  - Exactly 8 beats accepted, 1/cycle.
  - grp_idx sequence 0,0,1,1,2,2,3,3, with each group's bias applied.
  - out_last only on beat 8; done pulses once after it; busy then 0.
- Back-pressure: out_ready low for 3 cycles mid-layer → acc_ready low, out_data stable, no beat lost or duplicated; the total is still 8.
- Reset mid-layer: rst_n low after beat 3 → all outputs at reset values next edge. A new start runs a full 8-beat layer from grp_idx 0.
